kd_entry_ctrl: RTL and testbench

Keypad entry controller sitting between the keypad decoder and the occupancy-limit/display logic. It debounces the decoded key code and turns each physical press into exactly one event. It then sequences key events through an entry state machine that assembles up to four BCD digits, and hands the finished number downstream over a valid/ready handshake. The live entry buffer is exported for the 7-segment display path.

---
 rtl/kd_pkg.sv | 30 +++
 rtl/kd_debounce.sv | 76 +++++++
 rtl/kd_entry_ctrl.sv | 130 +++++++++++++
 tb/tb_kd_entry_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/kd_pkg.sv
// Shared key codes, state encodings and key-class helpers for the keypad entry controller.
package kd_pkg;

    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;
    localparam logic [3:0] KEY_NONE  = 4'hF;

    typedef enum logic [1:0] {
        EntIdle,
        EntEntry,
        EntCommit
    } entry_state_e;

    typedef enum logic [1:0] {
        DbRel,
        DbPressWait,
        DbPressed,
        DbRelWait
    } db_state_e;

    // Codes 0xC-0xE carry no meaning and behave exactly like KEY_NONE.
    function automatic logic key_is_none(input logic [3:0] code);
        return code >= 4'hC;
    endfunction

    function automatic logic key_is_digit(input logic [3:0] code);
        return code <= 4'h9;
    endfunction

endpackage

// File: rtl/kd_debounce.sv
// Debounces the decoded key code: one event per press, none on release or bounce.
module kd_debounce
    import kd_pkg::*;
#(
    parameter logic [15:0] DebounceCycles = 16'd50000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] key_code_i,
    output logic       event_o,
    output logic [3:0] code_o
);

    db_state_e   state_q;
    logic [15:0] cnt_q;
    logic [3:0]  code_q;
    logic        stable;
    logic        none;

    assign stable  = (key_code_i == code_q);
    assign none    = key_is_none(key_code_i);
    // Event fires in the cycle the count completes so the entry FSM acts on that edge.
    assign event_o = (state_q == DbPressWait) && stable && (cnt_q == DebounceCycles);
    assign code_o  = code_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= DbRel;
            cnt_q   <= 16'd0;
            code_q  <= 4'd0;
        end else begin
            case (state_q)
                DbRel: begin
                    if (!none) begin
                        state_q <= DbPressWait;
                        code_q  <= key_code_i;
                        cnt_q   <= 16'd0;
                    end
                end
                DbPressWait: begin
                    if (!stable) begin
                        state_q <= DbRel;
                        cnt_q   <= 16'd0;
                    end else if (cnt_q == DebounceCycles) begin
                        state_q <= DbPressed;
                        cnt_q   <= 16'd0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                DbPressed: begin
                    if (none) begin
                        state_q <= DbRelWait;
                        cnt_q   <= 16'd0;
                    end
                end
                DbRelWait: begin
                    if (!none) begin
                        state_q <= DbPressed;
                        cnt_q   <= 16'd0;
                    end else if (cnt_q == DebounceCycles) begin
                        state_q <= DbRel;
                        cnt_q   <= 16'd0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= DbRel;
                    cnt_q   <= 16'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/kd_entry_ctrl.sv
// Keypad entry controller: assembles up to four BCD digits from debounced key events
// and hands the committed number downstream over a valid/ready handshake.
module kd_entry_ctrl
    import kd_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [27:0] TIMEOUT_CYCLES  = 28'd250000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  key_code,
    output logic [15:0] entry_bcd,
    output logic [2:0]  digit_count,
    output logic [15:0] value_bcd,
    output logic        value_valid,
    input  logic        value_ready,
    output logic        key_event,
    output logic        entry_err,
    output logic        entry_timeout
);

    logic       db_event;
    logic [3:0] db_code;

    kd_debounce #(
        .DebounceCycles(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .key_code_i (key_code),
        .event_o    (db_event),
        .code_o     (db_code)
    );

    entry_state_e state_q;
    logic [15:0]  entry_bcd_q;
    logic [2:0]   count_q;
    logic [15:0]  value_bcd_q;
    logic         value_valid_q;
    logic         key_event_q;
    logic         entry_err_q;
    logic         entry_timeout_q;
    logic [27:0]  tmo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= EntIdle;
            entry_bcd_q     <= 16'h0000;
            count_q         <= 3'd0;
            value_bcd_q     <= 16'h0000;
            value_valid_q   <= 1'b0;
            key_event_q     <= 1'b0;
            entry_err_q     <= 1'b0;
            entry_timeout_q <= 1'b0;
            tmo_q           <= 28'd0;
        end else begin
            key_event_q     <= db_event;
            entry_err_q     <= 1'b0;
            entry_timeout_q <= 1'b0;
            case (state_q)
                EntIdle: begin
                    tmo_q <= 28'd0;
                    if (db_event) begin
                        if (key_is_digit(db_code)) begin
                            entry_bcd_q <= {12'h000, db_code};
                            count_q     <= 3'd1;
                            state_q     <= EntEntry;
                        end else if (db_code == KEY_ENTER) begin
                            entry_err_q <= 1'b1;
                        end
                    end
                end
                EntEntry: begin
                    // An event in the same cycle as expiry wins and restarts the idle count.
                    if (db_event) begin
                        tmo_q <= 28'd0;
                        if (key_is_digit(db_code)) begin
                            if (count_q == 3'd4) begin
                                entry_err_q <= 1'b1;
                            end else begin
                                entry_bcd_q <= {entry_bcd_q[11:0], db_code};
                                count_q     <= count_q + 3'd1;
                            end
                        end else if (db_code == KEY_CLEAR) begin
                            entry_bcd_q <= 16'h0000;
                            count_q     <= 3'd0;
                            state_q     <= EntIdle;
                        end else if (db_code == KEY_ENTER) begin
                            value_bcd_q   <= entry_bcd_q;
                            value_valid_q <= 1'b1;
                            state_q       <= EntCommit;
                        end
                    end else if (tmo_q == TIMEOUT_CYCLES - 28'd1) begin
                        tmo_q           <= 28'd0;
                        entry_timeout_q <= 1'b1;
                        entry_bcd_q     <= 16'h0000;
                        count_q         <= 3'd0;
                        state_q         <= EntIdle;
                    end else begin
                        tmo_q <= tmo_q + 28'd1;
                    end
                end
                EntCommit: begin
                    tmo_q <= 28'd0;
                    if (db_event) begin
                        entry_err_q <= 1'b1;
                    end
                    if (value_valid_q && value_ready) begin
                        value_valid_q <= 1'b0;
                        entry_bcd_q   <= 16'h0000;
                        count_q       <= 3'd0;
                        state_q       <= EntIdle;
                    end
                end
                default: begin
                    state_q <= EntIdle;
                end
            endcase
        end
    end

    assign entry_bcd     = entry_bcd_q;
    assign digit_count   = count_q;
    assign value_bcd     = value_bcd_q;
    assign value_valid   = value_valid_q;
    assign key_event     = key_event_q;
    assign entry_err     = entry_err_q;
    assign entry_timeout = entry_timeout_q;

endmodule

// File: tb/tb_kd_entry_ctrl.sv
// Scoreboard bench for kd_entry_ctrl: stimulus queues expected post-event state,
// a negedge monitor pops and compares on every key_event or entry_timeout pulse.
module tb_kd_entry_ctrl;

    logic        clk;
    logic        rst_n;
    logic [3:0]  key_code;
    logic [15:0] entry_bcd;
    logic [2:0]  digit_count;
    logic [15:0] value_bcd;
    logic        value_valid;
    logic        value_ready;
    logic        key_event;
    logic        entry_err;
    logic        entry_timeout;

    kd_entry_ctrl #(
        .DEBOUNCE_CYCLES(16'd4),
        .TIMEOUT_CYCLES (28'd64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_code      (key_code),
        .entry_bcd     (entry_bcd),
        .digit_count   (digit_count),
        .value_bcd     (value_bcd),
        .value_valid   (value_valid),
        .value_ready   (value_ready),
        .key_event     (key_event),
        .entry_err     (entry_err),
        .entry_timeout (entry_timeout)
    );

    typedef struct {
        logic [15:0] bcd;
        logic [2:0]  cnt;
        logic        err;
        logic        tmo;
        logic        vld;
        logic [15:0] vbcd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   ev_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] bcd, input logic [2:0] cnt, input logic err,
                                input logic tmo, input logic vld, input logic [15:0] vbcd);
        exp_t e;
        e.bcd  = bcd;
        e.cnt  = cnt;
        e.err  = err;
        e.tmo  = tmo;
        e.vld  = vld;
        e.vbcd = vbcd;
        return e;
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (rst_n && (key_event || entry_timeout)) begin
            if (key_event) ev_cnt++;
            if (q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, key_event, entry_timeout}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("key_event", key_event, !e.tmo);
                chk("entry_timeout", entry_timeout, e.tmo);
                chk("entry_bcd", entry_bcd, e.bcd);
                chk("digit_count", digit_count, e.cnt);
                chk("entry_err", entry_err, e.err);
                chk("value_valid", value_valid, e.vld);
                chk("value_bcd", value_bcd, e.vbcd);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] code, input exp_t e);
        q.push_back(e);
        key_code = code;
        cyc(10);
        key_code = 4'hF;
        cyc(10);
    endtask

    initial begin
        int ev0;
        int n;
        rst_n       = 1'b0;
        key_code    = 4'hF;
        value_ready = 1'b0;
        cyc(3);
        chk("rst_entry_bcd", entry_bcd, 16'h0);
        chk("rst_digit_count", digit_count, 3'd0);
        chk("rst_value_valid", value_valid, 1'b0);
        chk("rst_value_bcd", value_bcd, 16'h0);
        chk("rst_pulses", {key_event, entry_err, entry_timeout}, 3'b000);
        rst_n = 1'b1;
        cyc(3);

        // Two digits
        ev0 = ev_cnt;
        press(4'h3, mk(16'h0003, 3'd1, 1'b0, 1'b0, 1'b0, 16'h0));
        press(4'h0, mk(16'h0030, 3'd2, 1'b0, 1'b0, 1'b0, 16'h0));
        chk("two_events", ev_cnt - ev0, 2);
        chk("t1_entry_bcd", entry_bcd, 16'h0030);
        chk("t1_digit_count", digit_count, 3'd2);
        press(4'hA, mk(16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0));

        // Bouncing key never settles long enough
        ev0 = ev_cnt;
        repeat (5) begin
            key_code = 4'h5;
            cyc(2);
            key_code = 4'hF;
            cyc(2);
        end
        cyc(8);
        chk("bounce_no_event", ev_cnt - ev0, 0);
        chk("bounce_entry_bcd", entry_bcd, 16'h0);

        // Buffer full
        press(4'h1, mk(16'h0001, 3'd1, 1'b0, 1'b0, 1'b0, 16'h0));
        press(4'h2, mk(16'h0012, 3'd2, 1'b0, 1'b0, 1'b0, 16'h0));
        press(4'h3, mk(16'h0123, 3'd3, 1'b0, 1'b0, 1'b0, 16'h0));
        press(4'h4, mk(16'h1234, 3'd4, 1'b0, 1'b0, 1'b0, 16'h0));
        press(4'h5, mk(16'h1234, 3'd4, 1'b1, 1'b0, 1'b0, 16'h0));
        press(4'hA, mk(16'h0000, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0));

        // Commit and handshake
        press(4'h1, mk(16'h0001, 3'd1, 1'b0, 1'b0, 1'b0, 16'h0));
        press(4'h2, mk(16'h0012, 3'd2, 1'b0, 1'b0, 1'b0, 16'h0));
        press(4'hB, mk(16'h0012, 3'd2, 1'b0, 1'b0, 1'b1, 16'h0012));
        for (int i = 0; i < 8; i++) begin
            chk("hold_valid", value_valid, 1'b1);
            chk("hold_value_bcd", value_bcd, 16'h0012);
            cyc(1);
        end
        press(4'h5, mk(16'h0012, 3'd2, 1'b1, 1'b0, 1'b1, 16'h0012));
        chk("pre_hs_valid", value_valid, 1'b1);
        value_ready = 1'b1;
        cyc(1);
        value_ready = 1'b0;
        chk("post_hs_valid", value_valid, 1'b0);
        chk("post_hs_entry_bcd", entry_bcd, 16'h0);
        chk("post_hs_count", digit_count, 3'd0);
        chk("post_hs_value_bcd", value_bcd, 16'h0012);
        value_ready = 1'b1;
        cyc(3);
        value_ready = 1'b0;
        chk("idle_ready_no_effect", value_valid, 1'b0);
        // Enter in IDLE is rejected, confirming the FSM went back to idle
        press(4'hB, mk(16'h0000, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0012));

        // Timeout
        press(4'h7, mk(16'h0007, 3'd1, 1'b0, 1'b0, 1'b0, 16'h0012));
        q.push_back(mk(16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 16'h0012));
        for (int i = 0; i < 100 && q.size() != 0; i++) cyc(1);
        chk("timeout_seen", q.size(), 0);
        q.delete();

        // Reset mid-entry
        press(4'h9, mk(16'h0009, 3'd1, 1'b0, 1'b0, 1'b0, 16'h0012));
        q.push_back(mk(16'h0098, 3'd2, 1'b0, 1'b0, 1'b0, 16'h0012));
        key_code = 4'h8;
        cyc(7);
        rst_n = 1'b0;
        #1;
        chk("arst_entry_bcd", entry_bcd, 16'h0);
        chk("arst_digit_count", digit_count, 3'd0);
        chk("arst_value_bcd", value_bcd, 16'h0);
        chk("arst_value_valid", value_valid, 1'b0);
        chk("arst_pulses", {key_event, entry_err, entry_timeout}, 3'b000);
        cyc(3);
        rst_n = 1'b1;
        q.push_back(mk(16'h0008, 3'd1, 1'b0, 1'b0, 1'b0, 16'h0));
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc(1);
            if (key_event) begin
                n = i;
                break;
            end
        end
        $display("held key accepted %0d edges after reset release", n);
        chk("reaccept_delay_ok", (n >= 5 && n <= 8), 1'b1);
        key_code = 4'hF;
        cyc(10);
        chk("no_pending_valid", value_valid, 1'b0);
        chk("queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
